kbd_read_port: RTL and testbench

KBD_READ_PORT -- requirements
Module: kbd_read_port

---
 rtl/kbd_read_port_pkg.sv | 20 ++
 rtl/kbd_read_port_byte_fifo.sv | 86 ++++++++
 rtl/kbd_read_port.sv | 95 +++++++++
 tb/tb_kbd_read_port.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_read_port_pkg.sv
// Shared LC3 package: keyboard register addresses and status bit positions.
// Provides the KBSR word builder used by the read port.
package kbd_read_port_pkg;

    localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;

    localparam int KBSR_READY_BIT = 15;
    localparam int KBSR_IE_BIT    = 14;

    function automatic logic [15:0] kbsr_word(input logic ready,
                                              input logic ie);
        logic [15:0] w;
        w = '0;
        w[KBSR_READY_BIT] = ready;
        w[KBSR_IE_BIT]    = ie;
        return w;
    endfunction

endpackage

// File: rtl/kbd_read_port_byte_fifo.sv
// kbd_byte_fifo: keyboard byte buffer.
// Ports: clk, reset (sync, active-high), push/din in, pop in,
//        head (oldest byte), full, empty.
// Build option KBD_FIFO_EN: DEPTH-entry circular FIFO (DEPTH power of two).
// Without it: one holding register plus a full flag; DEPTH is ignored.
// push while full and pop while empty are ignored.
module kbd_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

`ifdef KBD_FIFO_EN

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

`else

    localparam int unused_depth = DEPTH;

    logic [7:0] data;
    logic       full_q;

    assign full  = full_q;
    assign empty = !full_q;
    assign head  = data;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            data   <= 8'h00;
        end else if (push && !full_q) begin
            full_q <= 1'b1;
            data   <= din;
        end else if (pop && full_q) begin
            full_q <= 1'b0;
        end
    end

`endif

endmodule

// File: rtl/kbd_read_port.sv
// kbd_read_port: LC3 keyboard KBSR/KBDR read port with byte buffer.
// Ports: clk, reset (sync, active-high); device side dev_valid/dev_data/
//        dev_ready; CPU side addr, rd_en, wr_en, wr_data, registered
//        rd_data/rd_valid; irq = registered (ready & ie).
// Build option KBD_FIFO_EN selects a FIFO_DEPTH-entry buffer instead of a
// single holding register.
module kbd_read_port
    import kbd_read_port_pkg::*;
#(
    parameter logic [15:0] KBSR_ADDR  = KBSR_ADDR_DEF,
    parameter logic [15:0] KBDR_ADDR  = KBDR_ADDR_DEF,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dev_valid,
    input  logic [7:0]  dev_data,
    output logic        dev_ready,
    input  logic [15:0] addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        irq
);

    logic       full;
    logic       empty;
    logic [7:0] head;
    logic       ready;
    logic       push;
    logic       pop;
    logic       rd_kbsr;
    logic       rd_kbdr;
    logic       wr_kbsr;
    logic       ie;
    logic [7:0] last_byte;
    logic       unused_wr;

    // dev_ready comes only from buffer state, never from dev_valid.
    assign dev_ready = !full;
    assign ready     = !empty;
    assign push      = dev_valid && dev_ready;

    assign rd_kbsr = rd_en && (addr == KBSR_ADDR);
    assign rd_kbdr = rd_en && (addr == KBDR_ADDR);
    assign wr_kbsr = wr_en && (addr == KBSR_ADDR);

    // A byte pushed this cycle is not visible to a same-cycle pop,
    // because the pop qualifier uses the registered empty flag.
    assign pop = rd_kbdr && !empty;

    assign unused_wr = ^wr_data;

    kbd_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (dev_data),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data   <= 16'h0000;
            rd_valid  <= 1'b0;
            ie        <= 1'b0;
            irq       <= 1'b0;
            last_byte <= 8'h00;
        end else begin
            rd_valid <= rd_kbsr || rd_kbdr;
            if (rd_kbsr) begin
                // ie here is the pre-write value on a same-cycle write.
                rd_data <= kbsr_word(ready, ie);
            end else if (rd_kbdr) begin
                if (!empty) begin
                    rd_data   <= {8'h00, head};
                    last_byte <= head;
                end else begin
                    rd_data <= {8'h00, last_byte};
                end
            end
            if (wr_kbsr)
                ie <= wr_data[KBSR_IE_BIT];
            irq <= ready && ie;
        end
    end

endmodule

// File: tb/tb_kbd_read_port.sv
// Testbench for kbd_read_port: directed stimulus, scoreboard of expected
// read words drained by a monitor on rd_valid.
module tb_kbd_read_port;

    localparam logic [15:0] KBSR = 16'hFE00;
    localparam logic [15:0] KBDR = 16'hFE02;

    logic        clk;
    logic        reset;
    logic        dev_valid;
    logic [7:0]  dev_data;
    logic        dev_ready;
    logic [15:0] addr;
    logic        rd_en;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        irq;

    typedef struct {
        string       tag;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    kbd_read_port dut (
        .clk       (clk),
        .reset     (reset),
        .dev_valid (dev_valid),
        .dev_data  (dev_data),
        .dev_ready (dev_ready),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid cycle consumes one expected word.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_valid_unexpected actual=1 required=0 data=%h",
                         rd_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, rd_data, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e,
                      input string t);
        addr  = a;
        rd_en = 1'b1;
        sb.push_back('{t, e});
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        dev_data  = b;
        dev_valid = 1'b1;
        chk("dev_ready_before_push", {15'b0, dev_ready}, 16'h0001);
        tick();
        dev_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        dev_valid = 1'b0;
        dev_data  = 8'h00;
        addr      = 16'h0000;
        rd_en     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = 16'h0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_dev_ready", {15'b0, dev_ready}, 16'h0001);
        chk("rst_irq", {15'b0, irq}, 16'h0000);
        chk("rst_rd_valid", {15'b0, rd_valid}, 16'h0000);
        chk("rst_rd_data", rd_data, 16'h0000);
        rd(KBSR, 16'h0000, "rst_kbsr");
        chk("rd_valid_high", {15'b0, rd_valid}, 16'h0001);
        tick();
        chk("rd_valid_one_cycle", {15'b0, rd_valid}, 16'h0000);

        // Basic byte read
        push_byte(8'h41);
        rd(KBSR, 16'h8000, "kbsr_ready");
        rd(KBDR, 16'h0041, "kbdr_41");
        rd(KBSR, 16'h0000, "kbsr_after_pop");

        // Interrupt path
        wr(KBSR, 16'h4000);
        chk("irq_idle", {15'b0, irq}, 16'h0000);
        push_byte(8'h0D);
        chk("irq_same_edge", {15'b0, irq}, 16'h0000);
        tick();
        chk("irq_set", {15'b0, irq}, 16'h0001);
        rd(KBDR, 16'h000D, "kbdr_0d");
        chk("irq_pop_edge", {15'b0, irq}, 16'h0001);
        tick();
        chk("irq_cleared", {15'b0, irq}, 16'h0000);
        wr(KBSR, 16'h0000);

        // Simultaneous read and write returns the old ie
        addr    = KBSR;
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 16'h4000;
        sb.push_back('{"rw_old_ie", 16'h0000});
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        rd(KBSR, 16'h4000, "rw_new_ie");
        wr(KBSR, 16'h8000);
        rd(KBSR, 16'h0000, "ready_not_writable");
        wr(KBDR, 16'h4000);
        rd(KBSR, 16'h0000, "kbdr_write_ignored");

        // Fill to capacity and hold off
`ifdef KBD_FIFO_EN
        dev_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            dev_data = 8'(i);
            tick();
        end
        chk("full_after_4", {15'b0, dev_ready}, 16'h0000);
        dev_data = 8'h05;
        tick();
        tick();
        chk("held_off_05", {15'b0, dev_ready}, 16'h0000);
        rd(KBDR, 16'h0001, "fifo_01");
        chk("ready_after_pop", {15'b0, dev_ready}, 16'h0001);
        tick();
        dev_valid = 1'b0;
        chk("full_with_05", {15'b0, dev_ready}, 16'h0000);
        rd(KBDR, 16'h0002, "fifo_02");
        rd(KBDR, 16'h0003, "fifo_03");
        rd(KBDR, 16'h0004, "fifo_04");
        rd(KBDR, 16'h0005, "fifo_05");
        rd(KBSR, 16'h0000, "fifo_drained");
`else
        dev_valid = 1'b1;
        dev_data  = 8'h01;
        tick();
        chk("full_after_1", {15'b0, dev_ready}, 16'h0000);
        dev_data = 8'h02;
        tick();
        tick();
        chk("held_off_02", {15'b0, dev_ready}, 16'h0000);
        rd(KBDR, 16'h0001, "reg_01");
        chk("ready_after_pop", {15'b0, dev_ready}, 16'h0001);
        tick();
        dev_valid = 1'b0;
        chk("full_with_02", {15'b0, dev_ready}, 16'h0000);
        rd(KBDR, 16'h0002, "reg_02");
        rd(KBSR, 16'h0000, "reg_drained");
`endif

        // Push and pop together
        push_byte(8'h22);
        dev_valid = 1'b1;
        dev_data  = 8'h33;
        addr      = KBDR;
        rd_en     = 1'b1;
        sb.push_back('{"pushpop_22", 16'h0022});
        tick();
        rd_en = 1'b0;
`ifndef KBD_FIFO_EN
        tick();
`endif
        dev_valid = 1'b0;
        rd(KBSR, 16'h8000, "pushpop_ready");
        rd(KBDR, 16'h0033, "pushpop_33");

        // Push into empty buffer is not visible to a same-cycle pop
        dev_valid = 1'b1;
        dev_data  = 8'h44;
        addr      = KBDR;
        rd_en     = 1'b1;
        sb.push_back('{"empty_pushpop_last", 16'h0033});
        tick();
        rd_en     = 1'b0;
        dev_valid = 1'b0;
        rd(KBDR, 16'h0044, "empty_pushpop_44");

        // Empty read repeats last byte; other addresses do nothing
        push_byte(8'h7A);
        rd(KBSR, 16'h8000, "kbsr_7a");
        rd(KBDR, 16'h007A, "kbdr_7a");
        rd(KBDR, 16'h007A, "kbdr_empty_7a");
        addr  = 16'h1234;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("other_rd_valid", {15'b0, rd_valid}, 16'h0000);
        chk("other_rd_data_hold", rd_data, 16'h007A);
        rd(KBSR, 16'h0000, "kbsr_empty_after");

        // Reset while full
`ifdef KBD_FIFO_EN
        for (int i = 0; i < 4; i++)
            push_byte(8'hA0 + 8'(i));
`else
        push_byte(8'hA0);
`endif
        chk("full_before_reset", {15'b0, dev_ready}, 16'h0000);
        wr(KBSR, 16'h4000);
        tick();
        chk("irq_before_reset", {15'b0, irq}, 16'h0001);
        reset     = 1'b1;
        dev_valid = 1'b1;
        dev_data  = 8'hEE;
        addr      = KBDR;
        rd_en     = 1'b1;
        tick();
        reset     = 1'b0;
        rd_en     = 1'b0;
        dev_valid = 1'b0;
        chk("reset_dev_ready", {15'b0, dev_ready}, 16'h0001);
        chk("reset_rd_valid", {15'b0, rd_valid}, 16'h0000);
        chk("reset_rd_data", rd_data, 16'h0000);
        chk("reset_irq", {15'b0, irq}, 16'h0000);
        rd(KBSR, 16'h0000, "kbsr_after_reset");

        tick();
        tick();
        chk("sb_drain", 16'(sb.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
